// File: rtl/cpc_ram_pkg.sv
// Shared types and Gate Array port-decode constants for the CPC RAM banking controller.
package cpc_ram_pkg;

    typedef logic [2:0] cfg_t;
    typedef logic [1:0] quadrant_t;

    localparam logic       GA_PORT_A15   = 1'b0;
    localparam logic       GA_PORT_A14   = 1'b1;
    localparam logic [1:0] RAMCFG_TAG    = 2'b11;
    localparam int         MAX_BANK_BITS = 6;

endpackage

// File: rtl/cpc_ram_map.sv
// RAM-config lookup: maps the registered config and the live quadrant to an
// external-RAM select and the 16K page within the current 64K bank.
module cpc_ram_map (
    input  logic [2:0] i_cfg,
    input  logic [1:0] i_q,
    output logic       o_sel,
    output logic [1:0] o_page
);
    import cpc_ram_pkg::*;

    cfg_t      w_cfg;
    quadrant_t w_q;

    assign w_cfg = i_cfg;
    assign w_q   = i_q;

    always_comb begin
        o_sel  = 1'b0;
        o_page = 2'd0;
        case (w_cfg)
            3'd1, 3'd3: begin
                if (w_q == 2'd3) begin
                    o_sel  = 1'b1;
                    o_page = 2'd3;
                end
            end
            3'd2: begin
                o_sel  = 1'b1;
                o_page = w_q;
            end
            3'd4, 3'd5, 3'd6, 3'd7: begin
                // Configs 4..7 overlay a single page into the &4000 window.
                if (w_q == 2'd1) begin
                    o_sel  = 1'b1;
                    o_page = w_cfg[1:0];
                end
            end
            default: begin
                o_sel  = 1'b0;
                o_page = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM banking controller: Gate Array RAM-config decode, SRAM strobes and HIADR.
// Optional wait-state insertion is enabled with macro CPC_RAM_WAIT_STATE_EN.
module cpc_ram_bank_ctrl #(
    parameter int         BANK_BITS   = 3,
    parameter logic [2:0] RESET_CFG   = 3'd0,
    parameter int         WAIT_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [15:0]          A,
    input  logic [7:0]           D,
    input  logic                 MREQ_B,
    input  logic                 IOREQ_B,
    input  logic                 RD_B,
    input  logic                 WR_B,
    input  logic                 RFSH_B,
    output logic                 RAMDIS,
    output logic                 RAMCS_B,
    output logic                 RAMOE_B,
    output logic                 RAMWE_B,
    output logic [BANK_BITS+1:0] HIADR,
    output logic                 READY
);
    import cpc_ram_pkg::*;

    logic                 w_iowr;
    logic                 w_commit;
    logic                 r_iowr_q;
    cfg_t                 r_cfg;
    logic [BANK_BITS-1:0] r_bank;
    logic [BANK_BITS-1:0] w_bank_new;
    logic                 w_sel;
    logic [1:0]           w_page;
    logic                 w_xsel;
    logic [BANK_BITS+1:0] r_hiadr;
    logic                 w_unused;

    assign w_iowr = ~IOREQ_B & ~WR_B & (A[15] == GA_PORT_A15) & (A[14] == GA_PORT_A14)
                  & (D[7:6] == RAMCFG_TAG);
    // One commit per IO cycle, however long the Z80 holds the strobes.
    assign w_commit = w_iowr & ~r_iowr_q;

    generate
        if (BANK_BITS > 3) begin : g_ext_bank
            assign w_bank_new = {~A[BANK_BITS+4:8], D[5:3]};
        end else begin : g_base_bank
            assign w_bank_new = D[5:3];
        end
    endgenerate

    assign w_unused = &{1'b0, A[13:0]};

    cpc_ram_map u_map (
        .i_cfg  (r_cfg),
        .i_q    (A[15:14]),
        .o_sel  (w_sel),
        .o_page (w_page)
    );

    // Reset gates the select so outputs sit at their idle values throughout reset.
    assign w_xsel = w_sel & ~MREQ_B & RFSH_B & ~RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_iowr_q <= 1'b0;
            r_cfg    <= RESET_CFG;
            r_bank   <= '0;
            r_hiadr  <= '0;
        end else begin
            r_iowr_q <= w_iowr;
            if (w_commit) begin
                r_cfg  <= D[2:0];
                r_bank <= w_bank_new;
            end
            if (w_xsel) begin
                r_hiadr <= {r_bank, w_page};
            end
        end
    end

    assign RAMDIS  = w_xsel;
    assign RAMCS_B = ~w_xsel;
    assign RAMOE_B = ~(w_xsel & ~RD_B);
    assign RAMWE_B = ~(w_xsel & ~WR_B);
    assign HIADR   = RESET ? '0 : (w_xsel ? {r_bank, w_page} : r_hiadr);

`ifdef CPC_RAM_WAIT_STATE_EN
    logic [1:0] r_wait_cnt;

    // Down-counter rearmed whenever the select drops; READY is low until it hits zero.
    always_ff @(posedge CLK) begin
        if (RESET || !w_xsel) begin
            r_wait_cnt <= 2'(WAIT_CYCLES);
        end else if (r_wait_cnt != 2'd0) begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
        end
    end

    assign READY = ~(w_xsel & (r_wait_cnt != 2'd0));
`else
    assign READY = 1'b1;
`endif

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Bench for cpc_ram_bank_ctrl (BANK_BITS=5, WAIT_CYCLES=2): directed cases plus
// random traffic against a behavioural model checked every cycle.
module tb_cpc_ram_bank_ctrl;
    localparam int         BB   = 5;
    localparam int         HW   = BB + 2;
    localparam int         WC   = 2;
    localparam logic [2:0] RCFG = 3'd0;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [15:0]   A;
    logic [7:0]    D;
    logic          MREQ_B, IOREQ_B, RD_B, WR_B, RFSH_B;
    logic          RAMDIS, RAMCS_B, RAMOE_B, RAMWE_B, READY;
    logic [HW-1:0] HIADR;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cfg    = 0;
    int m_bank   = 0;
    int m_iowr_q = 0;
    int m_hiadr  = 0;
    int m_run    = 0;

    cpc_ram_bank_ctrl #(.BANK_BITS(BB), .RESET_CFG(RCFG), .WAIT_CYCLES(WC)) dut (
        .CLK(CLK), .RESET(RESET), .A(A), .D(D),
        .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B), .RFSH_B(RFSH_B),
        .RAMDIS(RAMDIS), .RAMCS_B(RAMCS_B), .RAMOE_B(RAMOE_B), .RAMWE_B(RAMWE_B),
        .HIADR(HIADR), .READY(READY)
    );

    always #5 CLK = ~CLK;

    function automatic void model_map(input int cfg, input int q, output bit sel, output int page);
        sel  = 1'b0;
        page = 0;
        if (cfg == 1 || cfg == 3) begin
            if (q == 3) begin sel = 1'b1; page = 3; end
        end else if (cfg == 2) begin
            sel = 1'b1; page = q;
        end else if (cfg >= 4) begin
            if (q == 1) begin sel = 1'b1; page = cfg - 4; end
        end
    endfunction

    function automatic bit model_xsel(output int page);
        bit sel;
        model_map(m_cfg, int'(A[15:14]), sel, page);
        return sel && !MREQ_B && RFSH_B && !RESET;
    endfunction

    task automatic check_cycle();
        logic [HW+4:0] exp_v, act_v;
        int  page;
        bit  xs;
        bit  rdy;
        xs  = model_xsel(page);
        rdy = 1'b1;
`ifdef CPC_RAM_WAIT_STATE_EN
        if (xs && m_run < WC) rdy = 1'b0;
`endif
        if (RESET) exp_v = {1'b0, 1'b1, 1'b1, 1'b1, HW'(0), 1'b1};
        else exp_v = {xs, !xs, !(xs && !RD_B), !(xs && !WR_B),
                      HW'(xs ? m_bank * 4 + page : m_hiadr), rdy};
        act_v = {RAMDIS, RAMCS_B, RAMOE_B, RAMWE_B, HIADR, READY};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t A=%h D=%h actual=%b required=%b",
                     $time, A, D, act_v, exp_v);
        end
    endtask

    task automatic model_edge();
        int  page;
        bit  xs;
        bit  iowr;
        int  ext;
        if (RESET) begin
            m_cfg = int'(RCFG); m_bank = 0; m_iowr_q = 0; m_hiadr = 0; m_run = 0;
        end else begin
            xs = model_xsel(page);
            if (xs) m_hiadr = m_bank * 4 + page;
            m_run = xs ? (m_run < 1000 ? m_run + 1 : m_run) : 0;
            iowr = !IOREQ_B && !WR_B && A[15:14] == 2'b01 && D[7:6] == 2'b11;
            if (iowr && m_iowr_q == 0) begin
                ext    = (~int'(A[15:8])) & ((1 << (BB - 3)) - 1);
                m_cfg  = int'(D[2:0]);
                m_bank = ext * 8 + int'(D[5:3]);
            end
            m_iowr_q = iowr ? 1 : 0;
        end
    endtask

    task automatic apply(input logic rst, input logic [15:0] a, input logic [7:0] d,
                         input logic mreq, input logic ioreq, input logic rd,
                         input logic wr, input logic rfsh);
        RESET = rst; A = a; D = d;
        MREQ_B = mreq; IOREQ_B = ioreq; RD_B = rd; WR_B = wr; RFSH_B = rfsh;
        #2;
        check_cycle();
    endtask

    task automatic advance();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic io_wr(input logic [15:0] port, input logic [7:0] d);
        apply(1'b0, port, d, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        advance();
    endtask

    task automatic mem_rd(input logic [15:0] a);
        apply(1'b0, a, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        RESET = 1'b1; A = '0; D = '0;
        MREQ_B = 1'b1; IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1; RFSH_B = 1'b1;
        @(posedge CLK); #1;

        repeat (2) begin
            apply(1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            advance();
        end

        mem_rd(16'hC000);
        lit("rst_ramdis", 32'(RAMDIS), 0);
        lit("rst_ramcs_b", 32'(RAMCS_B), 1);
        lit("rst_ready", 32'(READY), 1);
        advance();

        io_wr(16'h7F00, 8'hC1);
        mem_rd(16'hC123);
        lit("cfg1_ramdis", 32'(RAMDIS), 1);
        lit("cfg1_ramoe_b", 32'(RAMOE_B), 0);
        lit("cfg1_hiadr", 32'(HIADR), 32'b0000011);
        advance();
        mem_rd(16'h4000);
        lit("cfg1_q1_ramdis", 32'(RAMDIS), 0);
        advance();

        // Port &7E00: A[9:8]=10 inverted gives bank[4:3]=01, D[5:3]=2 -> bank 01010, cfg 6.
        io_wr(16'h7E00, 8'hD6);
        apply(1'b0, 16'h4010, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        lit("cfg6_ramwe_b", 32'(RAMWE_B), 0);
        lit("cfg6_hiadr", 32'(HIADR), 32'b0101010);
        advance();

        // Strobes held for three cycles while D changes: only the first value may land.
        io_wr(16'h7F00, 8'hC1);
        io_wr(16'h7F00, 8'hC2);
        io_wr(16'h7F00, 8'hC2);
        apply(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        advance();
        mem_rd(16'h0000);
        lit("one_commit_q0", 32'(RAMDIS), 0);
        advance();
        mem_rd(16'hC000);
        lit("one_commit_q3", 32'(RAMDIS), 1);
        advance();

        io_wr(16'h7F00, 8'hC0);
        mem_rd(16'hC000);
        lit("cfg0_q3", 32'(RAMDIS), 0);
        advance();
        mem_rd(16'h4000);
        lit("cfg0_q1", 32'(RAMDIS), 0);
        advance();

        io_wr(16'h7F00, 8'hC2);
        apply(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        lit("rfsh_ramcs_b", 32'(RAMCS_B), 1);
        lit("rfsh_ramdis", 32'(RAMDIS), 0);
        advance();

`ifdef CPC_RAM_WAIT_STATE_EN
        apply(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        advance();
        mem_rd(16'h0000); lit("wait_c1", 32'(READY), 0); advance();
        mem_rd(16'h0000); lit("wait_c2", 32'(READY), 0); advance();
        mem_rd(16'h0000); lit("wait_c3", 32'(READY), 1); advance();
        apply(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        advance();
        apply(1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        advance();
        mem_rd(16'h0000); lit("wait_after_rst", 32'(READY), 1); advance();
`endif

        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [15:0] a;
            logic [7:0]  d;
            logic        mq, io, rd, wr, rf;
            r  = $urandom_range(0, 99);
            a  = 16'($urandom);
            d  = 8'($urandom);
            mq = 1'b1; io = 1'b1; rd = 1'b1; wr = 1'b1; rf = 1'b1;
            if (r < 25) begin
                a[15:14] = 2'b01;
                if ($urandom_range(0, 3) != 0) d[7:6] = 2'b11;
                io = 1'b0; wr = 1'b0;
            end else if (r < 90) begin
                mq = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 1) == 1) rd = 1'b0; else wr = 1'b0;
                rf = ($urandom_range(0, 7) != 0);
            end else begin
                {mq, io, rd, wr, rf} = 5'($urandom);
            end
            apply(($urandom_range(0, 59) == 0), a, d, mq, io, rd, wr, rf);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
